sprite_line_engine: RTL and testbench

- Parametrised OAM scan/fetch engine for the PPU, successor to the fixed 40-entry/10-slot sprite unit.
- Scans OAM during mode 2 and latches up to SLOTS sprites on the current line into a slot buffer.
- During mode 3, serves fetch requests to the pixel fetcher: tile number, attributes, row and VRAM address.
- Adds a per-line count, an overflow flag, and run-time selection between DMG and CGB tie-break rules.
- OAM RAM stays outside this block; the engine drives the external OAM read port.

---
 rtl/sprite_pkg.sv | 45 ++++
 rtl/sprite_slot_arbiter.sv | 40 ++++
 rtl/sprite_line_engine.sv | 343 ++++++++++++++++++++++++++++++++++
 tb/tb_sprite_line_engine.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared encodings and constants for the sprite line engine (scan FSM, fetch FSM, OAM layout).
// Optional statistics in the engine are enabled with SPRITE_LINE_STATS_EN.
package sprite_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_Y    = 2'd1,
        S_X    = 2'd2,
        S_DONE = 2'd3
    } scan_state_t;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_TILE = 2'd1,
        F_ATTR = 2'd2,
        F_WAIT = 2'd3
    } fetch_state_t;

    localparam logic [1:0] OFS_Y    = 2'd0;
    localparam logic [1:0] OFS_X    = 2'd1;
    localparam logic [1:0] OFS_TILE = 2'd2;
    localparam logic [1:0] OFS_ATTR = 2'd3;

    localparam logic [8:0] H_8X8       = 9'd8;
    localparam logic [8:0] H_8X16      = 9'd16;
    localparam logic [8:0] Y_OFFSET    = 9'd16;
    localparam logic [7:0] Y_VIS_LIMIT = 8'd160;

    // Returns {hit, row}; OAM Y is biased by 16 so the compare runs in 9 bits.
    function automatic logic [4:0] y_probe(input logic [7:0] v, input logic [7:0] y,
                                           input logic tall);
        logic [8:0] line9;
        logic [8:0] top9;
        logic [8:0] h9;
        logic       hit;
        logic [3:0] row;
        line9 = {1'b0, v} + Y_OFFSET;
        top9  = {1'b0, y};
        h9    = tall ? H_8X16 : H_8X8;
        hit   = (y < Y_VIS_LIMIT) && (line9 >= top9) && (line9 < (top9 + h9));
        row   = line9[3:0] - top9[3:0];
        return {hit, row};
    endfunction

endpackage

// File: rtl/sprite_slot_arbiter.sv
// Combinational slot matcher: finds slots whose X equals h_cnt and picks the winner
// by CGB (slot order) or DMG (lowest X, then slot order) priority.
module sprite_slot_arbiter
    import sprite_pkg::*;
#(
    parameter int SLOTS = 10
) (
    input  logic [7:0] slot_x [SLOTS],
    input  logic [7:0] h_cnt,
    input  logic       cgb_mode,
    output logic       match,
    output logic [3:0] win_slot
);

    logic [7:0] best_x;

    // Scan slots in ascending order; strict less-than keeps ties on the lower slot.
    always_comb begin
        match    = 1'b0;
        win_slot = 4'd0;
        best_x   = 8'hFF;
        for (int i = 0; i < SLOTS; i++) begin
            if (slot_x[i] == h_cnt) begin
                if (!match) begin
                    match    = 1'b1;
                    win_slot = 4'(i);
                    best_x   = slot_x[i];
                end else if (!cgb_mode && (slot_x[i] < best_x)) begin
                    win_slot = 4'(i);
                    best_x   = slot_x[i];
                end else begin
                    best_x = best_x;
                end
            end else begin
                best_x = best_x;
            end
        end
    end

endmodule

// File: rtl/sprite_line_engine.sv
// OAM scan (mode 2) and sprite fetch service (mode 3) for the PPU.
// Define SPRITE_LINE_STATS_EN to add max_line_count / ovf_lines statistics outputs.
module sprite_line_engine
    import sprite_pkg::*;
#(
    parameter int OAM_ENTRIES = 40,
    parameter int SLOTS       = 10,
    parameter int IDX_W       = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        lcd_on,
    input  logic        size16,
    input  logic        cgb_mode,
    input  logic [7:0]  v_cnt,
    input  logic [7:0]  h_cnt,
    input  logic        eval_start,
    output logic        eval_busy,
    output logic        eval_done,
    output logic [7:0]  oam_rd_addr,
    output logic        oam_rd_en,
    input  logic [7:0]  oam_q,
    input  logic        fetch_en,
    output logic        fetch_req,
    input  logic        fetch_ack,
    output logic [7:0]  sprite_attr,
    output logic [10:0] sprite_addr,
    output logic [3:0]  sprite_slot,
    output logic [4:0]  line_count,
    output logic        line_overflow
`ifdef SPRITE_LINE_STATS_EN
    ,
    output logic [4:0]  max_line_count,
    output logic [7:0]  ovf_lines
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OAM_ENTRIES - 1);
    localparam logic [4:0]       SLOTS_W  = 5'(SLOTS);

    scan_state_t      scan_q, scan_d;
    logic [IDX_W-1:0] idx_q, idx_d, yidx_q, yidx_d;
    logic [7:0]       y_q, y_d;
    logic             pend_q, pend_d, last_q, last_d, skip_q, skip_d;
    logic [7:0]       slot_x_q   [SLOTS];
    logic [7:0]       slot_x_d   [SLOTS];
    logic [IDX_W-1:0] slot_idx_q [SLOTS];
    logic [IDX_W-1:0] slot_idx_d [SLOTS];
    logic [3:0]       slot_row_q [SLOTS];
    logic [3:0]       slot_row_d [SLOTS];
    logic [4:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    fetch_state_t     fst_q, fst_d;
    logic [3:0]       cur_q, cur_d;
    logic [7:0]       tile_q, tile_d, attr_q, attr_d;
    logic             attr_pend_q, attr_pend_d, ack_q, ack_d;

    logic             start_s, eval_busy_s, match_s, fetch_req_s, retire_s;
    logic [3:0]       win_s;
    logic [4:0]       probe_s;
    logic [IDX_W-1:0] cur_idx_s;
    logic [7:0]       eff_attr_s;
    logic [3:0]       row_eff_s;

    // A start pulse is swallowed once after the LCD comes back on.
    assign start_s     = ce & lcd_on & eval_start & ~skip_q;
    assign eval_busy_s = (scan_q == S_Y) || (scan_q == S_X);
    assign probe_s     = y_probe(v_cnt, y_q, size16);
    assign fetch_req_s = match_s & fetch_en & ~eval_busy_s;
    assign cur_idx_s   = slot_idx_q[cur_q];

    sprite_slot_arbiter #(.SLOTS(SLOTS)) u_arbiter (
        .slot_x   (slot_x_q),
        .h_cnt    (h_cnt),
        .cgb_mode (cgb_mode),
        .match    (match_s),
        .win_slot (win_s)
    );

    // Scan FSM next state plus slot buffer, line count and overflow updates.
    always_comb begin
        scan_d     = scan_q;
        idx_d      = idx_q;
        yidx_d     = yidx_q;
        y_d        = y_q;
        pend_d     = pend_q;
        last_d     = last_q;
        skip_d     = skip_q;
        slot_x_d   = slot_x_q;
        slot_idx_d = slot_idx_q;
        slot_row_d = slot_row_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        if (ce) begin
            if (!lcd_on || start_s) begin
                scan_d = lcd_on ? S_Y : S_IDLE;
                skip_d = ~lcd_on;
                idx_d  = '0;
                pend_d = 1'b0;
                last_d = 1'b0;
                cnt_d  = 5'd0;
                ovf_d  = 1'b0;
                for (int i = 0; i < SLOTS; i++) begin
                    slot_x_d[i] = 8'hFF;
                end
            end else if (eval_start) begin
                skip_d = 1'b0;
            end else begin
                if (retire_s) begin
                    slot_x_d[cur_q] = 8'hFF;
                end else begin
                    skip_d = skip_q;
                end
                case (scan_q)
                    S_Y: begin
                        // The X byte of the previous entry arrives while Y of the next is addressed.
                        if (pend_q && probe_s[4]) begin
                            if (cnt_q < SLOTS_W) begin
                                slot_x_d[cnt_q[3:0]]   = oam_q;
                                slot_idx_d[cnt_q[3:0]] = yidx_q;
                                slot_row_d[cnt_q[3:0]] = probe_s[3:0];
                                cnt_d                  = cnt_q + 5'd1;
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end else begin
                            ovf_d = ovf_q;
                        end
                        scan_d = last_q ? S_DONE : S_X;
                    end
                    S_X: begin
                        y_d    = oam_q;
                        yidx_d = idx_q;
                        pend_d = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            last_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                        scan_d = S_Y;
                    end
                    S_IDLE:  scan_d = S_IDLE;
                    S_DONE:  scan_d = S_DONE;
                    default: scan_d = S_IDLE;
                endcase
            end
        end else begin
            scan_d = scan_q;
        end
    end

    // Fetch FSM: tile and attribute reads from OAM, then wait for the fetcher's ack edge.
    always_comb begin
        fst_d       = fst_q;
        cur_d       = cur_q;
        tile_d      = tile_q;
        attr_d      = attr_q;
        attr_pend_d = attr_pend_q;
        ack_d       = ack_q;
        retire_s    = 1'b0;
        if (ce) begin
            ack_d = fetch_ack;
            if (!lcd_on || !fetch_en || eval_busy_s || start_s) begin
                fst_d       = F_IDLE;
                attr_pend_d = 1'b0;
            end else begin
                case (fst_q)
                    F_IDLE: begin
                        if (fetch_req_s) begin
                            cur_d = win_s;
                            fst_d = F_TILE;
                        end else begin
                            fst_d = F_IDLE;
                        end
                    end
                    F_TILE: fst_d = F_ATTR;
                    F_ATTR: begin
                        tile_d      = oam_q;
                        attr_pend_d = 1'b1;
                        fst_d       = F_WAIT;
                    end
                    F_WAIT: begin
                        if (attr_pend_q) begin
                            attr_d      = oam_q;
                            attr_pend_d = 1'b0;
                        end else begin
                            attr_d = attr_q;
                        end
                        if (fetch_ack && !ack_q) begin
                            retire_s = 1'b1;
                            fst_d    = F_IDLE;
                        end else begin
                            fst_d = F_WAIT;
                        end
                    end
                    default: fst_d = F_IDLE;
                endcase
            end
        end else begin
            fst_d = fst_q;
        end
    end

    // Attribute is taken straight from OAM in the first wait cycle, from the latch afterwards.
    always_comb begin
        eff_attr_s = attr_pend_q ? oam_q : attr_q;
        row_eff_s  = eff_attr_s[6] ? ~slot_row_q[cur_q] : slot_row_q[cur_q];
        if (size16) begin
            sprite_addr = {tile_q[7:1], row_eff_s};
        end else begin
            sprite_addr = {tile_q, row_eff_s[2:0]};
        end
    end

    // OAM port mux; the scan always owns the port while it runs.
    always_comb begin
        case (scan_q)
            S_Y: oam_rd_addr = 8'({idx_q, OFS_Y});
            S_X: oam_rd_addr = 8'({idx_q, OFS_X});
            default: begin
                if (fst_q == F_TILE) begin
                    oam_rd_addr = 8'({cur_idx_s, OFS_TILE});
                end else if (fst_q == F_ATTR) begin
                    oam_rd_addr = 8'({cur_idx_s, OFS_ATTR});
                end else begin
                    oam_rd_addr = 8'h00;
                end
            end
        endcase
    end

    assign eval_busy     = eval_busy_s;
    assign eval_done     = (scan_q == S_DONE);
    assign oam_rd_en     = eval_busy_s | (fst_q == F_TILE) | (fst_q == F_ATTR);
    assign fetch_req     = fetch_req_s;
    assign sprite_attr   = eff_attr_s;
    assign sprite_slot   = cur_q;
    assign line_count    = cnt_q;
    assign line_overflow = ovf_q;

    // Scan state and slot buffer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_q <= S_IDLE;
            idx_q  <= '0;
            yidx_q <= '0;
            y_q    <= 8'h00;
            pend_q <= 1'b0;
            last_q <= 1'b0;
            skip_q <= 1'b0;
            cnt_q  <= 5'd0;
            ovf_q  <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                slot_x_q[i]   <= 8'hFF;
                slot_idx_q[i] <= '0;
                slot_row_q[i] <= 4'd0;
            end
        end else begin
            scan_q     <= scan_d;
            idx_q      <= idx_d;
            yidx_q     <= yidx_d;
            y_q        <= y_d;
            pend_q     <= pend_d;
            last_q     <= last_d;
            skip_q     <= skip_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            slot_x_q   <= slot_x_d;
            slot_idx_q <= slot_idx_d;
            slot_row_q <= slot_row_d;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fst_q       <= F_IDLE;
            cur_q       <= 4'd0;
            tile_q      <= 8'h00;
            attr_q      <= 8'h00;
            attr_pend_q <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            fst_q       <= fst_d;
            cur_q       <= cur_d;
            tile_q      <= tile_d;
            attr_q      <= attr_d;
            attr_pend_q <= attr_pend_d;
            ack_q       <= ack_d;
        end
    end

`ifdef SPRITE_LINE_STATS_EN
    logic [4:0] max_q, max_d;
    logic [7:0] ovl_q, ovl_d;
    logic       lcd_q, lcd_d;

    // Peak count since LCD enable; overflowed lines per frame, saturating.
    always_comb begin
        max_d = max_q;
        ovl_d = ovl_q;
        lcd_d = lcd_q;
        if (ce) begin
            lcd_d = lcd_on;
            if (lcd_on && !lcd_q) begin
                max_d = 5'd0;
            end else if (cnt_q > max_q) begin
                max_d = cnt_q;
            end else begin
                max_d = max_q;
            end
            if (start_s && (v_cnt == 8'd0)) begin
                ovl_d = 8'd0;
            end else if (ovf_d && !ovf_q && (ovl_q != 8'hFF)) begin
                ovl_d = ovl_q + 8'd1;
            end else begin
                ovl_d = ovl_q;
            end
        end else begin
            lcd_d = lcd_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_q <= 5'd0;
            ovl_q <= 8'd0;
            lcd_q <= 1'b0;
        end else begin
            max_q <= max_d;
            ovl_q <= ovl_d;
            lcd_q <= lcd_d;
        end
    end

    assign max_line_count = max_q;
    assign ovf_lines      = ovl_q;
`endif

endmodule

// File: tb/tb_sprite_line_engine.sv
// Self-checking bench for sprite_line_engine: behavioural OAM plus a line/fetch reference model.
module tb_sprite_line_engine;

    localparam int N = 40;
    localparam int S = 10;

    logic        clk = 1'b0, reset = 1'b1, ce = 1'b1, lcd_on = 1'b1;
    logic        size16 = 1'b0, cgb_mode = 1'b0;
    logic [7:0]  v_cnt = 8'd0, h_cnt = 8'd0;
    logic        eval_start = 1'b0, fetch_en = 1'b0, fetch_ack = 1'b0;
    logic        eval_busy, eval_done, oam_rd_en, fetch_req, line_overflow;
    logic [7:0]  oam_rd_addr, sprite_attr;
    logic [7:0]  oam_q = 8'd0;
    logic [10:0] sprite_addr;
    logic [3:0]  sprite_slot;
    logic [4:0]  line_count;
    logic [7:0]  oam_mem [256];

    int checks_total = 0;
    int checks_passed = 0;
    int exp_cnt;
    bit exp_ovf;
    int exp_idx [16];
    int cur_v;
    bit cur_s16;

    sprite_line_engine dut (
        .clk(clk), .reset(reset), .ce(ce), .lcd_on(lcd_on), .size16(size16),
        .cgb_mode(cgb_mode), .v_cnt(v_cnt), .h_cnt(h_cnt), .eval_start(eval_start),
        .eval_busy(eval_busy), .eval_done(eval_done), .oam_rd_addr(oam_rd_addr),
        .oam_rd_en(oam_rd_en), .oam_q(oam_q), .fetch_en(fetch_en), .fetch_req(fetch_req),
        .fetch_ack(fetch_ack), .sprite_attr(sprite_attr), .sprite_addr(sprite_addr),
        .sprite_slot(sprite_slot), .line_count(line_count), .line_overflow(line_overflow)
    );

    always #5 clk = ~clk;

    // External OAM: synchronous read, one ce of latency.
    always @(posedge clk) if (ce) oam_q <= oam_mem[oam_rd_addr];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_oam;
        for (int i = 0; i < 256; i++) oam_mem[i] = 8'd200;
    endtask

    // Reference: sprites in OAM order whose Y window covers the line.
    task automatic model_scan;
        int n = 0;
        for (int e = 0; e < N; e++) begin
            int y = oam_mem[4*e];
            int h = cur_s16 ? 16 : 8;
            if (y < 160 && cur_v + 16 >= y && cur_v + 16 < y + h) begin
                if (n < S) exp_idx[n] = e;
                n++;
            end
        end
        exp_cnt = (n < S) ? n : S;
        exp_ovf = (n > S);
    endtask

    function automatic int exp_addr(int idx);
        int y = oam_mem[4*idx];
        int t = oam_mem[4*idx+2];
        int a = oam_mem[4*idx+3];
        int row = (cur_v + 16 - y) % 16;
        if ((a & 64) != 0) row = 15 - row;
        if (cur_s16) return (t / 2) * 16 + row;
        return t * 8 + (row % 8);
    endfunction

    task automatic run_scan(input string name);
        int n = 0;
        fetch_en = 1'b0;
        v_cnt = 8'(cur_v);
        size16 = cur_s16;
        model_scan();
        eval_start = 1'b1;
        tick();
        eval_start = 1'b0;
        while (!eval_done && n < 200) begin
            tick();
            n++;
        end
        checks_total++;
        if (n !== 2*N+1) $display("FAIL %s scan_len: got %0d ce, expected %0d", name, n, 2*N+1);
        else checks_passed++;
        checks_total++;
        if (line_count !== 5'(exp_cnt) || line_overflow !== exp_ovf)
            $display("FAIL %s count: got %0d/%0b, expected %0d/%0b", name, line_count, line_overflow, exp_cnt, exp_ovf);
        else checks_passed++;
    endtask

    // Sweep every X position and compare the served fetch sequence with the model.
    task automatic sweep(input string name);
        logic [22:0] expq[$];
        logic [22:0] obsq[$];
        bit stuck = 1'b0;
        for (int h = 0; h < 255; h++)
            for (int s = 0; s < exp_cnt; s++)
                if (oam_mem[4*exp_idx[s]+1] == 8'(h))
                    expq.push_back({4'(s), oam_mem[4*exp_idx[s]+3], 11'(exp_addr(exp_idx[s]))});
        fetch_en = 1'b1;
        for (int h = 0; h < 255; h++) begin
            int k = 0;
            h_cnt = 8'(h);
            #1;
            while (fetch_req && k < 20) begin
                tick(); tick(); tick();
                obsq.push_back({sprite_slot, sprite_attr, sprite_addr});
                fetch_ack = 1'b1;
                tick();
                fetch_ack = 1'b0;
                k++;
            end
            if (k == 20) stuck = 1'b1;
        end
        fetch_en = 1'b0;
        tick();
        checks_total++;
        if (stuck || obsq.size() != expq.size())
            $display("FAIL %s fetch_count: got %0d fetches (stuck=%0b), expected %0d", name, obsq.size(), stuck, expq.size());
        else checks_passed++;
        for (int i = 0; i < obsq.size() && i < expq.size(); i++) begin
            checks_total++;
            if (obsq[i] !== expq[i])
                $display("FAIL %s fetch[%0d]: got slot/attr/addr %h, expected %h", name, i, obsq[i], expq[i]);
            else checks_passed++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        fetch_en = 1'b1;
        h_cnt = 8'd10;
        repeat (3) tick();
        checks_total++;
        if ({eval_busy, eval_done, fetch_req, line_overflow, oam_rd_en, line_count, sprite_attr} !== 18'd0)
            $display("FAIL reset_hold: got %b, expected all zero", {eval_busy, eval_done, fetch_req, line_overflow, oam_rd_en, line_count, sprite_attr});
        else checks_passed++;
        reset = 1'b0;
        tick();
        checks_total++;
        if ({eval_busy, eval_done, fetch_req, line_overflow, oam_rd_en, line_count} !== 10'd0)
            $display("FAIL reset_release: got %b, expected all zero", {eval_busy, eval_done, fetch_req, line_overflow, oam_rd_en, line_count});
        else checks_passed++;
        fetch_en = 1'b0;
    endtask

    task automatic test_single;
        clear_oam();
        oam_mem[0] = 8'd36; oam_mem[1] = 8'd50; oam_mem[2] = 8'h5A; oam_mem[3] = 8'h00;
        cur_v = 20; cur_s16 = 1'b0; cgb_mode = 1'b1;
        run_scan("single");
        sweep("single");
    endtask

    task automatic test_overflow;
        clear_oam();
        for (int e = 0; e < 12; e++) begin
            oam_mem[4*e] = 8'd36;
            oam_mem[4*e+1] = 8'(100 + e);
            oam_mem[4*e+2] = 8'(3*e + 1);
            oam_mem[4*e+3] = 8'($urandom);
        end
        cur_v = 20; cur_s16 = 1'b0; cgb_mode = 1'b0;
        run_scan("overflow");
        sweep("overflow");
    endtask

    task automatic test_size16_flip;
        clear_oam();
        oam_mem[0] = 8'd30; oam_mem[1] = 8'd60; oam_mem[2] = 8'h23; oam_mem[3] = 8'h40;
        cur_v = 20; cur_s16 = 1'b1;
        run_scan("size16");
        fetch_en = 1'b1;
        h_cnt = 8'd60;
        #1;
        checks_total++;
        if (fetch_req !== 1'b1) $display("FAIL size16 req: got %b, expected 1", fetch_req);
        else checks_passed++;
        tick();
        checks_total++;
        if (oam_rd_en !== 1'b1 || oam_rd_addr !== 8'h02) $display("FAIL size16 tile_rd: got %b/%h, expected 1/02", oam_rd_en, oam_rd_addr);
        else checks_passed++;
        tick();
        checks_total++;
        if (oam_rd_en !== 1'b1 || oam_rd_addr !== 8'h03) $display("FAIL size16 attr_rd: got %b/%h, expected 1/03", oam_rd_en, oam_rd_addr);
        else checks_passed++;
        tick();
        checks_total++;
        if (sprite_addr !== 11'(exp_addr(0)) || sprite_attr !== 8'h40)
            $display("FAIL size16 addr: got %h/%h, expected %h/40", sprite_addr, sprite_attr, 11'(exp_addr(0)));
        else checks_passed++;
        tick();
        checks_total++;
        if (sprite_addr !== 11'(exp_addr(0)) || sprite_attr !== 8'h40)
            $display("FAIL size16 addr_hold: got %h/%h, expected %h/40", sprite_addr, sprite_attr, 11'(exp_addr(0)));
        else checks_passed++;
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
        checks_total++;
        if (fetch_req !== 1'b0) $display("FAIL size16 retire: got req %b, expected 0", fetch_req);
        else checks_passed++;
        fetch_en = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        for (int m = 0; m < 2; m++) begin
            clear_oam();
            for (int e = 0; e < 3; e++) begin
                oam_mem[4*e] = 8'd36;
                oam_mem[4*e+1] = (e == 2) ? 8'd41 : 8'd40;
                oam_mem[4*e+2] = 8'(8'h10 + e);
                oam_mem[4*e+3] = 8'h00;
            end
            cur_v = 20; cur_s16 = 1'b0; cgb_mode = m[0];
            run_scan("b2b");
            fetch_en = 1'b1;
            h_cnt = 8'd40;
            tick(); tick(); tick();
            checks_total++;
            if (sprite_slot !== 4'd0) $display("FAIL b2b first_slot: got %0d, expected 0", sprite_slot);
            else checks_passed++;
            fetch_ack = 1'b1;
            tick();
            fetch_ack = 1'b0;
            checks_total++;
            if (fetch_req !== 1'b1) $display("FAIL b2b second_req: got %b, expected 1", fetch_req);
            else checks_passed++;
            tick();
            checks_total++;
            if (oam_rd_en !== 1'b1 || oam_rd_addr !== 8'h06) $display("FAIL b2b second_rd: got %b/%h, expected 1/06", oam_rd_en, oam_rd_addr);
            else checks_passed++;
            tick(); tick();
            checks_total++;
            if (sprite_slot !== 4'd1 || sprite_addr !== 11'(exp_addr(1)))
                $display("FAIL b2b second_slot: got %0d/%h, expected 1/%h", sprite_slot, sprite_addr, 11'(exp_addr(1)));
            else checks_passed++;
            fetch_ack = 1'b1;
            tick();
            fetch_ack = 1'b0;
            checks_total++;
            if (fetch_req !== 1'b0) $display("FAIL b2b drained: got req %b, expected 0", fetch_req);
            else checks_passed++;
            fetch_en = 1'b0;
            tick();
        end
    endtask

    task automatic test_restart;
        int n = 0;
        test_overflow();
        model_scan();
        eval_start = 1'b1;
        tick();
        eval_start = 1'b0;
        repeat (41) tick();
        checks_total++;
        if (eval_busy !== 1'b1 || line_count !== 5'd10) $display("FAIL restart mid: got busy %b count %0d, expected 1/10", eval_busy, line_count);
        else checks_passed++;
        eval_start = 1'b1;
        tick();
        eval_start = 1'b0;
        checks_total++;
        if (line_count !== 5'd0 || line_overflow !== 1'b0) $display("FAIL restart clear: got %0d/%b, expected 0/0", line_count, line_overflow);
        else checks_passed++;
        while (!eval_done && n < 200) begin
            tick();
            n++;
        end
        checks_total++;
        if (n !== 2*N+1 || line_count !== 5'(exp_cnt) || line_overflow !== exp_ovf)
            $display("FAIL restart rerun: got %0d ce %0d/%b, expected %0d ce %0d/%b", n, line_count, line_overflow, 2*N+1, exp_cnt, exp_ovf);
        else checks_passed++;
    endtask

    task automatic test_lcd;
        lcd_on = 1'b0;
        repeat (3) tick();
        checks_total++;
        if (line_count !== 5'd0 || eval_done !== 1'b0 || eval_busy !== 1'b0)
            $display("FAIL lcd_off: got count %0d done %b busy %b, expected 0/0/0", line_count, eval_done, eval_busy);
        else checks_passed++;
        lcd_on = 1'b1;
        tick();
        eval_start = 1'b1;
        tick();
        eval_start = 1'b0;
        repeat (5) tick();
        checks_total++;
        if (eval_busy !== 1'b0 || eval_done !== 1'b0) $display("FAIL lcd_skip: got busy %b done %b, expected 0/0", eval_busy, eval_done);
        else checks_passed++;
        run_scan("lcd_resume");
    endtask

    task automatic test_ce_gating;
        int n = 0;
        clear_oam();
        for (int e = 0; e < 6; e++) begin
            oam_mem[4*e] = 8'(40 + e);
            oam_mem[4*e+1] = 8'(20 * e + 5);
            oam_mem[4*e+2] = 8'($urandom);
            oam_mem[4*e+3] = 8'($urandom);
        end
        cur_v = 30; cur_s16 = 1'b0;
        v_cnt = 8'(cur_v); size16 = cur_s16;
        model_scan();
        eval_start = 1'b1;
        tick();
        eval_start = 1'b0;
        for (int i = 0; i < 1000 && !eval_done; i++) begin
            ce = 1'($urandom_range(0, 1));
            tick();
            if (ce) n++;
        end
        ce = 1'b1;
        checks_total++;
        if (n !== 2*N+1 || line_count !== 5'(exp_cnt))
            $display("FAIL ce_gate: got %0d ce count %0d, expected %0d ce count %0d", n, line_count, 2*N+1, exp_cnt);
        else checks_passed++;
        sweep("ce_gate");
    endtask

    task automatic test_random;
        for (int it = 0; it < 4; it++) begin
            clear_oam();
            cur_v = $urandom_range(0, 143);
            cur_s16 = 1'($urandom_range(0, 1));
            cgb_mode = 1'($urandom_range(0, 1));
            for (int e = 0; e < N; e++) begin
                int yv = cur_v + 16 - $urandom_range(0, 22);
                if (yv < 0) yv = 0;
                if ($urandom_range(0, 9) == 0) yv = $urandom_range(160, 255);
                oam_mem[4*e] = 8'(yv);
                oam_mem[4*e+1] = 8'($urandom_range(0, 254));
                oam_mem[4*e+2] = 8'($urandom);
                oam_mem[4*e+3] = 8'($urandom);
            end
            run_scan("random");
            sweep("random");
        end
    endtask

    task automatic test_reset_midfetch;
        test_single();
        model_scan();
        eval_start = 1'b1;
        tick();
        eval_start = 1'b0;
        repeat (2*N+1) tick();
        fetch_en = 1'b1;
        h_cnt = 8'd50;
        tick(); tick();
        reset = 1'b1;
        #1;
        checks_total++;
        if (fetch_req !== 1'b0 || line_count !== 5'd0)
            $display("FAIL reset_midfetch: got req %b count %0d, expected 0/0", fetch_req, line_count);
        else checks_passed++;
        tick();
        reset = 1'b0;
        fetch_en = 1'b0;
        tick();
    endtask

    initial begin
        clear_oam();
        test_reset();
        test_single();
        test_overflow();
        test_size16_flip();
        test_back_to_back();
        test_restart();
        test_lcd();
        test_ce_gating();
        test_random();
        test_reset_midfetch();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
